mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/answer memory between two requesters: the
//  fetch port (instruction/operand reads driven by the control unit MAR path)
//  and the store port (ALU result writes and read-backs via the MARR/PR path).
//  One transaction at a time; round-robin between simultaneous requests.
//  Sits between the control unit datapath and the memory macro.
// PARAMETERS
//  ADDR_W  8  address width, both ports and memory
//  DATA_W  8  data width
//  RD_LAT  1  memory read latency in cycles after the enable cycle (legal 1..3)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  f_req      in   1       fetch request (read-only); held until f_ack
//  f_addr     in   ADDR_W  fetch address; stable while f_req is high
//  f_ack      out  1       one-cycle pulse; f_rdata valid in the same cycle
//  f_rdata    out  DATA_W  fetch read data (registered)
//  s_req      in   1       store-port request; held until s_ack
//  s_we       in   1       1 = write, 0 = read
//  s_addr     in   ADDR_W  store-port address
//  s_wdata    in   DATA_W  store-port write data
//  s_ack      out  1       one-cycle pulse; write done, or s_rdata valid
//  s_rdata    out  DATA_W  store-port read data (registered)
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable (only with mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid RD_LAT cycles after mem_en
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, last_grant=STORE (fetch wins first tie). All
//    outputs 0, including rdata registers. Reset mid-transaction abandons it:
//    mem_en/mem_we drop immediately and no ack is issued.
//  - FSM: IDLE -> ISSUE -> (WAIT x RD_LAT, reads only) -> DONE -> IDLE.
//  - IDLE: on a clock edge with any req high, latch owner, addr, wdata, we
//    (fetch: we=0) and go to ISSUE. Both high: grant the port not in
//    last_grant. last_grant updates on acceptance.
//  - ISSUE (1 cycle): mem_en=1, mem_addr/mem_wdata/mem_we from latched values.
//    Write -> DONE; read -> WAIT, load counter with RD_LAT.
//  - WAIT: counter decrements each cycle; at the last count, mem_rdata is
//    captured into the owner's rdata register and the FSM goes to DONE.
//  - DONE (1 cycle): owner's ack=1, then IDLE. rdata holds until next capture.
//  - Latency req->ack: write 3 cycles, read 3+RD_LAT cycles. A held req is
//    re-sampled in IDLE, so back-to-back transactions have 1 idle cycle min.
//  - Requests during busy are not sampled. No queueing.
//  - Request dropped before its ack: the transaction still completes and the
//    ack still pulses. Requesters ignore unexpected acks.
//  - Address/data changes after acceptance are ignored (latched copy used).
//  - mem_* outputs are 0 in every state except ISSUE.
//  - f_ack and s_ack are never high in the same cycle.
// CONFIGURATION
//  ARB_FETCH_PRIO_EN defined: fixed priority; fetch wins every tie and
//    last_grant is unused. Store can starve under continuous fetch traffic.
//  Undefined (default): round-robin as above. No starvation; worst-case store
//    wait is one full fetch transaction.
// TESTING
//  1 Fetch read, RD_LAT=1, mem[0x10]=0xA5: f_req,f_addr=0x10 -> mem_en one
//    cycle with addr 0x10; f_ack 4 cycles after req; f_rdata=0xA5.
//  2 Store write s_addr=0x80,s_wdata=0x3C: mem_we=1 for one cycle; s_ack 3
//    cycles after req; read-back via store port returns 0x3C.
//  3 f_req and s_req both raised on the same cycle after reset -> fetch served
//    first, store second. Repeat the tie -> order alternates (round-robin);
//    with ARB_FETCH_PRIO_EN, fetch wins every time.
//  4 RD_LAT=3 read -> exactly 3 WAIT cycles; ack 6 cycles after req; data
//    equals the value mem_rdata had 3 cycles after mem_en.
//  5 reset pulled low during WAIT -> busy, mem_en and ack are 0 at once; no
//    ack after release; next request completes normally.
//  6 f_req dropped during WAIT -> f_ack still pulses once; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between a read-only fetch port and
//            a read/write store port. One transaction at a time. Ties between
//            the ports are settled round-robin by default.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   ARB_FETCH_PRIO_EN  defined   -> fixed priority, fetch wins every tie
//                      undefined -> round-robin (default)
// ----------------------------------------------------------------------------
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   f_req_i       fetch request, held until f_ack_o
//   f_addr_i      fetch address
//   f_ack_o       one-cycle pulse, f_rdata_o valid in the same cycle
//   f_rdata_o     fetch read data (registered, holds until next capture)
//   s_req_i       store-port request, held until s_ack_o
//   s_we_i        1 = write, 0 = read
//   s_addr_i      store-port address
//   s_wdata_i     store-port write data
//   s_ack_o       one-cycle pulse, write done or s_rdata_o valid
//   s_rdata_o     store-port read data (registered)
//   mem_en_o      memory enable (only in ISSUE)
//   mem_we_o      memory write enable (only with mem_en_o)
//   mem_addr_o    memory address
//   mem_wdata_o   memory write data
//   mem_rdata_i   memory read data, valid RD_LAT cycles after mem_en_o
//   busy_o        high in every state except IDLE
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_ack_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              s_req_i,
  input  logic              s_we_i,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [DATA_W-1:0] s_wdata_i,
  output logic              s_ack_o,
  output logic [DATA_W-1:0] s_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int              CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic                owner_q;      // 1 = store port owns the transaction
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                f_ack_q;
  logic                s_ack_q;
  logic [DATA_W-1:0]   f_rdata_q;
  logic [DATA_W-1:0]   s_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                busy_q;
  logic                grant_store_d;
  logic                store_write_d;

`ifndef ARB_FETCH_PRIO_EN
  logic                last_grant_q; // 1 = store was granted last
`endif

  // Grant decision for the IDLE cycle. A lone request always wins; on a tie
  // the port that was not granted last goes first (or fetch, in fixed mode).
  always_comb begin
    grant_store_d = 1'b0;
    if (s_req_i && !f_req_i) begin
      grant_store_d = 1'b1;
    end
`ifndef ARB_FETCH_PRIO_EN
    else if (s_req_i && f_req_i) begin
      grant_store_d = ~last_grant_q;
    end
`endif
    store_write_d = grant_store_d & s_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      f_ack_q      <= 1'b0;
      s_ack_q      <= 1'b0;
      f_rdata_q    <= '0;
      s_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
`ifndef ARB_FETCH_PRIO_EN
      last_grant_q <= 1'b1;  // so that fetch wins the first tie
`endif
    end else begin
      // Pulse-type outputs default low; the memory bus is only driven in ISSUE.
      f_ack_q     <= 1'b0;
      s_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (f_req_i || s_req_i) begin
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
            owner_q     <= grant_store_d;
            we_q        <= store_write_d;
`ifndef ARB_FETCH_PRIO_EN
            last_grant_q <= grant_store_d;
`endif
            // The memory bus registers double as the latched request copy.
            mem_en_q    <= 1'b1;
            mem_we_q    <= store_write_d;
            mem_addr_q  <= grant_store_d ? s_addr_i : f_addr_i;
            mem_wdata_q <= grant_store_d ? s_wdata_i : '0;
          end
        end

        S_ISSUE: begin
          if (we_q) begin
            state_q <= S_DONE;
            s_ack_q <= owner_q;
            f_ack_q <= ~owner_q;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_LOAD;
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            if (owner_q) begin
              s_rdata_q <= mem_rdata_i;
            end else begin
              f_rdata_q <= mem_rdata_i;
            end
            state_q <= S_DONE;
            s_ack_q <= owner_q;
            f_ack_q <= ~owner_q;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign f_ack_o     = f_ack_q;
  assign s_ack_o     = s_ack_q;
  assign f_rdata_o   = f_rdata_q;
  assign s_rdata_o   = s_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
